// File: rtl/iop_pkg.sv
// Shared types and defaults for the IOT pulse generator.
// Optional bus-skip sampling is enabled by defining IOP_SKIP_SAMPLE_EN.
package iop_pkg;

  localparam int PULSE_W_DEF = 4;
  localparam int GAP_W_DEF   = 8;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    P1   = 3'd1,
    G1   = 3'd2,
    P2   = 3'd3,
    G2   = 3'd4,
    P4   = 3'd5,
    G4   = 3'd6,
    DONE = 3'd7
  } iop_state_t;

  typedef logic [2:0] iop_bits_t;

  localparam int IOP1_IDX = 0;
  localparam int IOP2_IDX = 1;
  localparam int IOP4_IDX = 2;

endpackage

// File: rtl/iop_interval_counter.sv
// Loadable down-counter that times every pulse and gap slot.
// expired is high while the count sits at zero.
module iop_interval_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             expired
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign expired = (count == '0);

endmodule

// File: rtl/iop_pulse_generator.sv
// IOT timing stage: fixed IOP1/IOP2/IOP4 slots gated by captured MB bits.
// Defining IOP_SKIP_SAMPLE_EN adds the io_skip input and skip output.
module iop_pulse_generator
  import iop_pkg::*;
#(
  parameter int PULSE_W = PULSE_W_DEF,
  parameter int GAP_W   = GAP_W_DEF,
  parameter int CNT_W   = 8
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      iot_start,
  input  iop_bits_t mb_iop,
`ifdef IOP_SKIP_SAMPLE_EN
  input  logic      io_skip,
  output logic      skip,
`endif
  output logic      iop1,
  output logic      iop2,
  output logic      iop4,
  output logic      io_pause,
  output logic      iot_done
);

  if (PULSE_W < 1 || GAP_W < 1) begin : g_bad_width
    $error("PULSE_W and GAP_W must both be at least 1");
  end
  if ((64'd1 << CNT_W) <= 64'(PULSE_W) || (64'd1 << CNT_W) <= 64'(GAP_W)) begin : g_bad_cnt
    $error("CNT_W too narrow for PULSE_W/GAP_W");
  end

  localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(PULSE_W - 1);
  localparam logic [CNT_W-1:0] GAP_LD   = CNT_W'(GAP_W - 1);

  iop_state_t       state, next_state;
  iop_bits_t        cap, cap_next;
  logic             load, expired;
  logic [CNT_W-1:0] load_val;

  iop_interval_counter #(.CNT_W(CNT_W)) u_counter (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (load),
    .load_val(load_val),
    .expired (expired)
  );

  // Slot sequencing; the counter reloads whenever the state changes.
  always_comb begin
    next_state = state;
    cap_next   = cap;
    load_val   = '0;
    unique case (state)
      IDLE: if (iot_start) begin
        next_state = P1;
        cap_next   = mb_iop;
      end
      P1:   if (expired) next_state = G1;
      G1:   if (expired) next_state = P2;
      P2:   if (expired) next_state = G2;
      G2:   if (expired) next_state = P4;
      P4:   if (expired) next_state = G4;
      G4:   if (expired) next_state = DONE;
      DONE: next_state = IDLE;
      default: next_state = IDLE;
    endcase
    load = (next_state != state);
    case (next_state)
      P1, P2, P4: load_val = PULSE_LD;
      G1, G2, G4: load_val = GAP_LD;
      default:    load_val = '0;
    endcase
  end

  // Outputs are registered from the next state so iop1 rises on the start edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cap      <= '0;
      iop1     <= 1'b0;
      iop2     <= 1'b0;
      iop4     <= 1'b0;
      io_pause <= 1'b0;
      iot_done <= 1'b0;
    end else begin
      state    <= next_state;
      cap      <= cap_next;
      iop1     <= (next_state == P1) & cap_next[IOP1_IDX];
      iop2     <= (next_state == P2) & cap_next[IOP2_IDX];
      iop4     <= (next_state == P4) & cap_next[IOP4_IDX];
      io_pause <= (next_state != IDLE) && (next_state != DONE);
      iot_done <= (next_state == DONE);
    end
  end

`ifdef IOP_SKIP_SAMPLE_EN
  logic skip_flag, skip_flag_next, skip_sample;

  // io_skip only counts on the final cycle of an enabled pulse slot.
  always_comb begin
    skip_sample = expired & (((state == P1) & cap[IOP1_IDX]) |
                             ((state == P2) & cap[IOP2_IDX]) |
                             ((state == P4) & cap[IOP4_IDX]));
    if (state == IDLE && iot_start) begin
      skip_flag_next = 1'b0;
    end else begin
      skip_flag_next = skip_flag | (skip_sample & io_skip);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      skip_flag <= 1'b0;
      skip      <= 1'b0;
    end else begin
      skip_flag <= skip_flag_next;
      skip      <= skip_flag_next & (next_state == DONE);
    end
  end
`endif

endmodule
